// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 9;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam pc_t PROG_LEN_DEFAULT = 16'd256;

  typedef enum logic {FS_RUN, FS_HALT} fetch_state_e;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } q_entry_t;

  // Branch target; relative targets wrap silently mod 2^PC_W.
  function automatic pc_t branch_target(input logic is_abs, input pc_t base, input pc_t offset);
    return is_abs ? offset : pc_t'(base + offset);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ROM, downstream handshake and redirect signals of the fetch unit.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  pc_t    rom_addr;
  instr_t rom_data;
  instr_t instr_out;
  pc_t    instr_pc;
  logic   instr_valid;
  logic   instr_ready;
  logic   redirect;
  logic   redirect_abs;
  pc_t    redirect_pc;
  pc_t    redirect_offset;
  logic   done;

  modport master (
    output rom_addr, instr_out, instr_pc, instr_valid, done,
    input  rom_data, instr_ready, redirect, redirect_abs, redirect_pc, redirect_offset
  );

  modport slave (
    input  rom_addr, instr_out, instr_pc, instr_valid, done,
    output rom_data, instr_ready, redirect, redirect_abs, redirect_pc, redirect_offset
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// Small flushable FIFO of {instruction, pc}; flush wins over push.
module instr_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  q_entry_t         push_data,
  input  logic             pop,
  input  logic             flush,
  output q_entry_t         head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  q_entry_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC sequencing, ROM issue, instruction queue, redirects and done.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter pc_t PROG_LEN = PROG_LEN_DEFAULT,
  parameter int  DEPTH    = 2
) (
  input  logic CLK,
  input  logic reset,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  fetch_state_e     state_reg;
  pc_t              fetch_pc_reg;
  pc_t              issue_pc_reg;
  logic             inflight_reg;
  logic             done_reg;
  q_entry_t         head;
  q_entry_t         hold_reg;
  q_entry_t         push_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             redirect_go;
  logic             at_end;
  logic             issue;
  logic [OCC_W-1:0] occupancy;

  assign pop         = !empty && bus.instr_ready;
  assign redirect_go = bus.redirect && (state_reg == FS_RUN);
  assign at_end      = (fetch_pc_reg >= PROG_LEN);
  // Slots already promised: queued entries plus the ROM word in flight, minus this cycle's pop.
  assign occupancy   = OCC_W'(count) + OCC_W'(inflight_reg) - OCC_W'(pop);
  assign issue       = (state_reg == FS_RUN) && !redirect_go && !at_end &&
                       (!full || pop) && (occupancy < OCC_W'(DEPTH));
  assign push_data   = '{instr: bus.rom_data, pc: issue_pc_reg};

  instr_queue #(.DEPTH(DEPTH)) u_queue (
    .CLK       (CLK),
    .reset     (reset),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_go),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // issue_pc_reg doubles as the held ROM address when nothing issues.
  assign bus.rom_addr    = issue ? fetch_pc_reg : issue_pc_reg;
  assign bus.instr_valid = !empty;
  assign bus.instr_out   = empty ? hold_reg.instr : head.instr;
  assign bus.instr_pc    = empty ? hold_reg.pc : head.pc;
  assign bus.done        = done_reg;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg    <= FS_RUN;
      fetch_pc_reg <= '0;
      issue_pc_reg <= '0;
      inflight_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        FS_RUN: begin
          if (redirect_go) begin
            fetch_pc_reg <= branch_target(bus.redirect_abs, bus.redirect_pc, bus.redirect_offset);
            inflight_reg <= 1'b0;
          end else begin
            inflight_reg <= issue;
            if (issue) begin
              issue_pc_reg <= fetch_pc_reg;
              fetch_pc_reg <= fetch_pc_reg + pc_t'(1);
            end
            if (at_end && empty && !inflight_reg) begin
              state_reg <= FS_HALT;
              done_reg  <= 1'b1;
            end
          end
        end
        FS_HALT: done_reg <= 1'b1;
        default: state_reg <= FS_RUN;
      endcase
    end
  end

  // Keeps instr_out/instr_pc stable while the queue is empty.
  always_ff @(posedge CLK) begin
    if (reset)       hold_reg <= '0;
    else if (!empty) hold_reg <= head;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency, streaming, backpressure, redirects, halt and reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic CLK    = 1'b0;
  logic reset  = 1'b1;
  logic reset8 = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  pc_t  exp_pc;

  fetch_unit_if b();
  fetch_unit_if b8();

  fetch_unit #(.PROG_LEN(PROG_LEN_DEFAULT), .DEPTH(2)) dut  (.CLK(CLK), .reset(reset),  .bus(b));
  fetch_unit #(.PROG_LEN(16'd8),            .DEPTH(2)) dut8 (.CLK(CLK), .reset(reset8), .bus(b8));

  always #5 CLK = ~CLK;

  // Synchronous ROMs: word k holds k[8:0].
  always @(posedge CLK) begin
    b.rom_data  <= b.rom_addr[8:0];
    b8.rom_data <= b8.rom_addr[8:0];
  end

  always @(negedge CLK) begin
    if (!reset && b.instr_valid && b.instr_ready)
      $display("xfer pc=%h instr=%h", b.instr_pc, b.instr_out);
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", b.instr_valid); else n_pass++;
    n_checks++; if (b.done !== 1'b0) $display("FAIL reset_done: got %b want 0", b.done); else n_pass++;
    n_checks++; if (b.instr_pc !== 16'h0000 || b.instr_out !== 9'h000) $display("FAIL reset_outs: pc=%h out=%h want 0/0", b.instr_pc, b.instr_out); else n_pass++;
    n_checks++; if (b.rom_addr !== 16'h0000) $display("FAIL reset_rom_addr: got %h want 0000", b.rom_addr); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL latency_r2: valid=%b want 0", b.instr_valid); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0000 || b.instr_out !== 9'h000) $display("FAIL latency_r3: valid=%b pc=%h out=%h want 1/0000/000", b.instr_valid, b.instr_pc, b.instr_out); else n_pass++;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      exp_pc = pc_t'(k);
      n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== exp_pc || b.instr_out !== exp_pc[8:0]) $display("FAIL stream: valid=%b pc=%h out=%h want pc=%h", b.instr_valid, b.instr_pc, b.instr_out, exp_pc); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      b.instr_ready = 1'b0;
      #1;
      n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0005 || b.instr_out !== 9'h005) $display("FAIL stall_hold: valid=%b pc=%h out=%h want 1/0005/005", b.instr_valid, b.instr_pc, b.instr_out); else n_pass++;
      n_checks++; if (b.rom_addr > 16'h0007) $display("FAIL stall_rom_addr: got %h want <= 0007", b.rom_addr); else n_pass++;
    end
    for (int k = 5; k <= 8; k++) begin
      next_cycle();
      b.instr_ready = 1'b1;
      #1;
      exp_pc = pc_t'(k);
      n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== exp_pc || b.instr_out !== exp_pc[8:0]) $display("FAIL release: valid=%b pc=%h out=%h want pc=%h", b.instr_valid, b.instr_pc, b.instr_out, exp_pc); else n_pass++;
    end
  endtask

  task automatic test_redirect_rel();
    next_cycle();
    n_checks++; if (b.instr_pc !== 16'h0009) $display("FAIL pre_rel: pc=%h want 0009", b.instr_pc); else n_pass++;
    next_cycle();
    b.redirect = 1'b1; b.redirect_abs = 1'b0; b.redirect_pc = 16'h000A; b.redirect_offset = 16'hFFFC;
    #1;
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h000A) $display("FAIL rel_branch: valid=%b pc=%h want 1/000a", b.instr_valid, b.instr_pc); else n_pass++;
    next_cycle();
    b.redirect = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0 || b.rom_addr !== 16'h0006) $display("FAIL rel_t1: valid=%b rom_addr=%h want 0/0006", b.instr_valid, b.rom_addr); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL rel_t2: valid=%b want 0", b.instr_valid); else n_pass++;
    for (int k = 6; k <= 19; k++) begin
      next_cycle();
      exp_pc = pc_t'(k);
      n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== exp_pc || b.instr_out !== exp_pc[8:0]) $display("FAIL rel_stream: valid=%b pc=%h out=%h want pc=%h", b.instr_valid, b.instr_pc, b.instr_out, exp_pc); else n_pass++;
    end
  endtask

  task automatic test_redirect_abs();
    next_cycle();
    b.redirect = 1'b1; b.redirect_abs = 1'b1; b.redirect_pc = 16'h0014; b.redirect_offset = 16'h0040;
    #1;
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0014) $display("FAIL abs_branch: valid=%b pc=%h want 1/0014", b.instr_valid, b.instr_pc); else n_pass++;
    next_cycle();
    b.redirect = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL abs_t1: valid=%b want 0", b.instr_valid); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL abs_t2: valid=%b want 0", b.instr_valid); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0040 || b.instr_out !== 9'h040) $display("FAIL abs_t3: valid=%b pc=%h out=%h want 1/0040/040", b.instr_valid, b.instr_pc, b.instr_out); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_pc !== 16'h0041) $display("FAIL abs_next: pc=%h want 0041", b.instr_pc); else n_pass++;
  endtask

  task automatic test_redirect_wrap();
    next_cycle();
    b.redirect = 1'b1; b.redirect_abs = 1'b0; b.redirect_pc = 16'hFFF0; b.redirect_offset = 16'h0020;
    #1;
    n_checks++; if (b.instr_pc !== 16'h0042) $display("FAIL wrap_branch: pc=%h want 0042", b.instr_pc); else n_pass++;
    next_cycle();
    b.redirect = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0 || b.rom_addr !== 16'h0010) $display("FAIL wrap_t1: valid=%b rom_addr=%h want 0/0010", b.instr_valid, b.rom_addr); else n_pass++;
    next_cycle();
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0010 || b.instr_out !== 9'h010) $display("FAIL wrap_t3: valid=%b pc=%h out=%h want 1/0010/010", b.instr_valid, b.instr_pc, b.instr_out); else n_pass++;
  endtask

  task automatic test_redirect_beyond();
    next_cycle();
    b.redirect = 1'b1; b.redirect_abs = 1'b1; b.redirect_pc = 16'h0011; b.redirect_offset = 16'h0100;
    #1;
    n_checks++; if (b.instr_pc !== 16'h0011) $display("FAIL beyond_branch: pc=%h want 0011", b.instr_pc); else n_pass++;
    next_cycle();
    b.redirect = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL beyond_t1: valid=%b want 0", b.instr_valid); else n_pass++;
    next_cycle();
    n_checks++; if (b.done !== 1'b1 || b.instr_valid !== 1'b0) $display("FAIL beyond_done: done=%b valid=%b want 1/0", b.done, b.instr_valid); else n_pass++;
    next_cycle();
    b.redirect = 1'b1; b.redirect_abs = 1'b1; b.redirect_offset = 16'h0000;
    next_cycle();
    b.redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      n_checks++; if (b.done !== 1'b1 || b.instr_valid !== 1'b0 || b.rom_addr !== 16'h0012) $display("FAIL halt_ignore: done=%b valid=%b rom_addr=%h want 1/0/0012", b.done, b.instr_valid, b.rom_addr); else n_pass++;
    end
  endtask

  task automatic test_reset_full();
    next_cycle();
    reset = 1'b1;
    b.instr_ready = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0 || b.done !== 1'b0) $display("FAIL rst_from_halt: valid=%b done=%b want 0/0", b.instr_valid, b.done); else n_pass++;
    next_cycle();
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0000) $display("FAIL rst_restart: valid=%b pc=%h want 1/0000", b.instr_valid, b.instr_pc); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0000) $display("FAIL fill_hold: valid=%b pc=%h want 1/0000", b.instr_valid, b.instr_pc); else n_pass++;
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (b.instr_valid !== 1'b0 || b.done !== 1'b0) $display("FAIL rst_full_r1: valid=%b done=%b want 0/0", b.instr_valid, b.done); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b0) $display("FAIL rst_full_r2: valid=%b want 0", b.instr_valid); else n_pass++;
    next_cycle();
    b.instr_ready = 1'b1;
    #1;
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0000 || b.instr_out !== 9'h000) $display("FAIL rst_full_r3: valid=%b pc=%h out=%h want 1/0000/000", b.instr_valid, b.instr_pc, b.instr_out); else n_pass++;
    next_cycle();
    n_checks++; if (b.instr_valid !== 1'b1 || b.instr_pc !== 16'h0001) $display("FAIL rst_full_r4: valid=%b pc=%h want 1/0001", b.instr_valid, b.instr_pc); else n_pass++;
  endtask

  task automatic test_prog_end();
    int waited;
    b8.instr_ready = 1'b1;
    next_cycle();
    reset8 = 1'b0;
    #1;
    n_checks++; if (b8.instr_valid !== 1'b0 || b8.done !== 1'b0) $display("FAIL end_reset: valid=%b done=%b want 0/0", b8.instr_valid, b8.done); else n_pass++;
    next_cycle();
    for (int k = 0; k <= 7; k++) begin
      next_cycle();
      exp_pc = pc_t'(k);
      n_checks++; if (b8.instr_valid !== 1'b1 || b8.instr_pc !== exp_pc || b8.instr_out !== exp_pc[8:0]) $display("FAIL end_stream: valid=%b pc=%h out=%h want pc=%h", b8.instr_valid, b8.instr_pc, b8.instr_out, exp_pc); else n_pass++;
    end
    next_cycle();
    n_checks++; if (b8.instr_valid !== 1'b0) $display("FAIL end_after_last: valid=%b want 0", b8.instr_valid); else n_pass++;
    waited = 0;
    while (b8.done !== 1'b1 && waited < 6) begin
      next_cycle();
      waited++;
    end
    n_checks++; if (b8.done !== 1'b1) $display("FAIL end_done_timeout: done=%b want 1 within 6 cycles", b8.done); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      n_checks++; if (b8.done !== 1'b1 || b8.instr_valid !== 1'b0) $display("FAIL end_sticky: done=%b valid=%b want 1/0", b8.done, b8.instr_valid); else n_pass++;
    end
  endtask

  initial begin
    b.instr_ready = 1'b1; b.redirect = 1'b0; b.redirect_abs = 1'b0; b.redirect_pc = '0; b.redirect_offset = '0;
    b8.instr_ready = 1'b1; b8.redirect = 1'b0; b8.redirect_abs = 1'b0; b8.redirect_pc = '0; b8.redirect_offset = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_rel();
    test_redirect_abs();
    test_redirect_wrap();
    test_redirect_beyond();
    test_reset_full();
    test_prog_end();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
